wb_port_arbiter: RTL

//  Shares the single register-file write port between the pipeline write-back (MEM/WB

---
 rtl/wb_port_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority, long-latency unit
// results queue in an in-order buffer and force a pipeline freeze when starved or full.
module wb_port_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_reg_w,
    input  logic        wb_mem_to_reg,
    input  logic [31:0] wb_alu_result,
    input  logic [31:0] wb_mem_data,
    input  logic [4:0]  wb_rd_addr,
    input  logic        lu_valid,
    input  logic [4:0]  lu_rd_addr,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    input  logic [4:0]  chk_rs,
    input  logic [4:0]  chk_rt,
    output logic        pend_hit,
    output logic        stall_pipe,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_DRAIN  = 1'b1
    } state_t;

    state_t        state_r, state_next_s;
    logic [4:0]    buf_addr_r  [DEPTH];
    logic [31:0]   buf_data_r  [DEPTH];
    logic          buf_live_r  [DEPTH];
    logic          buf_stale_r [DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0] count_r, count_next_s;
    logic [SW-1:0] starve_r, starve_next_s;
    logic          rf_we_r;
    logic [4:0]    rf_waddr_r;
    logic [31:0]   rf_wdata_r;

    logic          stall_s, pw_s, push_s, store_s;
    logic          head_valid_s, head_stale_s, pop_s, lu_write_s;
    logic          pend_hit_s;
    logic [31:0]   pw_data_s;

    assign stall_s      = (state_r == ST_DRAIN);
    assign pw_s         = wb_reg_w & (wb_rd_addr != 5'd0) & ~stall_s;
    assign pw_data_s    = wb_mem_to_reg ? wb_mem_data : wb_alu_result;
    assign lu_ready     = (count_r < CW'(DEPTH));
    assign push_s       = lu_valid & lu_ready;
    // Writes to r0 are architecturally void, so they are accepted but never stored.
    assign store_s      = push_s & (lu_rd_addr != 5'd0);
    assign head_valid_s = (count_r != {CW{1'b0}});
    assign head_stale_s = buf_stale_r[rd_ptr_r];
    assign pop_s        = head_valid_s & (head_stale_s | ~pw_s);
    assign lu_write_s   = pop_s & ~head_stale_s;
    assign count_next_s = count_r + CW'(store_s) - CW'(pop_s);

    assign stall_pipe = stall_s;
    assign pend_hit   = pend_hit_s;
    assign rf_we      = rf_we_r;
    assign rf_waddr   = rf_waddr_r;
    assign rf_wdata   = rf_wdata_r;

    // Starvation counter next value.
    always_comb begin
        starve_next_s = starve_r;
        if (!head_valid_s || pop_s) begin
            starve_next_s = {SW{1'b0}};
        end else if (starve_r < SW'(STARVE_LIMIT)) begin
            starve_next_s = starve_r + SW'(1'b1);
        end else begin
            starve_next_s = starve_r;
        end
    end

    // Freeze FSM next state.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_NORMAL: begin
                if ((count_next_s == CW'(DEPTH)) || (starve_next_s == SW'(STARVE_LIMIT))) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_NORMAL;
                end
            end
            ST_DRAIN: begin
                if (count_next_s == {CW{1'b0}}) begin
                    state_next_s = ST_NORMAL;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: state_next_s = ST_NORMAL;
        endcase
    end

    // Hazard query against live, non-stale buffered destinations.
    always_comb begin
        pend_hit_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (buf_live_r[i] && !buf_stale_r[i] &&
                (((chk_rs != 5'd0) && (buf_addr_r[i] == chk_rs)) ||
                 ((chk_rt != 5'd0) && (buf_addr_r[i] == chk_rt)))) begin
                pend_hit_s = 1'b1;
            end else begin
                pend_hit_s = pend_hit_s;
            end
        end
    end

    // Buffer storage; a pipeline commit to the same rd supersedes buffered results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_addr_r[i]  <= 5'd0;
                buf_data_r[i]  <= 32'd0;
                buf_live_r[i]  <= 1'b0;
                buf_stale_r[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pw_s && buf_live_r[i] && (buf_addr_r[i] == wb_rd_addr)) begin
                    buf_stale_r[i] <= 1'b1;
                end
            end
            if (pop_s) begin
                buf_live_r[rd_ptr_r] <= 1'b0;
            end
            if (store_s) begin
                buf_addr_r[wr_ptr_r]  <= lu_rd_addr;
                buf_data_r[wr_ptr_r]  <= lu_data;
                buf_live_r[wr_ptr_r]  <= 1'b1;
                buf_stale_r[wr_ptr_r] <= pw_s && (lu_rd_addr == wb_rd_addr);
            end
        end
    end

    // Pointers, occupancy, starvation counter and FSM state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            starve_r <= {SW{1'b0}};
            state_r  <= ST_NORMAL;
        end else begin
            if (store_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            count_r  <= count_next_s;
            starve_r <= starve_next_s;
            state_r  <= state_next_s;
        end
    end

    // Registered write port: pipeline first, then a live buffer head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_r    <= 1'b0;
            rf_waddr_r <= 5'd0;
            rf_wdata_r <= 32'd0;
        end else if (pw_s) begin
            rf_we_r    <= 1'b1;
            rf_waddr_r <= wb_rd_addr;
            rf_wdata_r <= pw_data_s;
        end else if (lu_write_s) begin
            rf_we_r    <= 1'b1;
            rf_waddr_r <= buf_addr_r[rd_ptr_r];
            rf_wdata_r <= buf_data_r[rd_ptr_r];
        end else begin
            rf_we_r    <= 1'b0;
        end
    end

endmodule
